// File: rtl/gb80_alu_pkg.sv
// ----------------------------------------------------------------------------
// gb80_alu_pkg
// This package holds the declarations shared by the GB80 ALU datapath blocks.
//   - Sequencer state codes (S_IDLE, S_RUN, S_DONE) and the enum built on them.
//   - Bit positions of the Z/N/H/C flags in the GB80 F register.
//   - A helper that sizes a counter so it is never narrower than one bit.
// ----------------------------------------------------------------------------
package gb80_alu_pkg;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = S_IDLE,
        ST_RUN  = S_RUN,
        ST_DONE = S_DONE
    } alu_state_e;

    localparam int FLAG_Z = 7;
    localparam int FLAG_N = 6;
    localparam int FLAG_H = 5;
    localparam int FLAG_C = 4;

    // Width of a counter that must hold the values 0 .. n-1.
    function automatic int count_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/slice_subtractor.sv
// ----------------------------------------------------------------------------
// slice_subtractor
// This is a purely combinational subtractor that handles one SLICE_WIDTH-bit slice.
// It computes {borrow_out, diff} = a - b - borrow_in as a SLICE_WIDTH+1 bit
// two's-complement result. The top bit of that result is the borrow.
// Ports:
//   a, b        [SLICE_WIDTH-1:0]  minuend / subtrahend slice
//   borrow_in   1                  borrow into the slice LSB
//   diff        [SLICE_WIDTH-1:0]  difference slice
//   borrow_out  1                  borrow out of the slice MSB
// ----------------------------------------------------------------------------
module slice_subtractor #(
    parameter int SLICE_WIDTH = 4
) (
    input  logic [SLICE_WIDTH-1:0] a,
    input  logic [SLICE_WIDTH-1:0] b,
    input  logic                   borrow_in,
    output logic [SLICE_WIDTH-1:0] diff,
    output logic                   borrow_out
);

    logic [SLICE_WIDTH:0] wide_diff;

    // Zero-extend the operands by one bit. The extra bit goes to 1 when the
    // subtraction wraps below zero, so it is the borrow.
    assign wide_diff  = {1'b0, a} - {1'b0, b} - {{SLICE_WIDTH{1'b0}}, borrow_in};
    assign diff       = wide_diff[SLICE_WIDTH-1:0];
    assign borrow_out = wide_diff[SLICE_WIDTH];

endmodule

// File: rtl/bit_subtractor_seq.sv
// ----------------------------------------------------------------------------
// bit_subtractor_seq
// This is a multi-cycle subtractor. It computes A - B - borrow_in one slice
// per clock, starting at the LSB.
// It also produces the GB80 flags C (borrow out of the MSB), H (borrow out of
// bit 3) and Z (difference is zero).
// Sequence: IDLE -> RUN (N slices) -> DONE -> IDLE, where N = DATA_WIDTH/SLICE_WIDTH.
// o_valid pulses for one cycle after the DONE edge.
//
// Optional feature, enabled by the macro GB80_SUB_COMPARE_EN:
//   The macro adds the input i_compare, which is captured on accept.
//   When it is set, the flags are computed from the true difference, but
//   o_diff is reloaded with the captured minuend (CP semantics).
//
// Ports:
//   i_clk, i_rst_n          clock (rising edge) / async active-low reset
//   i_start                 request, accepted only while o_ready=1
//   i_data_A, i_data_B      operands [DATA_WIDTH-1:0], captured on accept
//   i_borrow_in             borrow into bit 0, captured on accept
//   i_compare               (GB80_SUB_COMPARE_EN only) compare mode
//   o_ready                 high in IDLE
//   o_valid                 one-cycle result-final pulse
//   o_diff                  difference, held until next accept
//   o_borrow_out            C flag
//   o_half_borrow           H flag
//   o_zero                  Z flag
// ----------------------------------------------------------------------------
module bit_subtractor_seq
    import gb80_alu_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int SLICE_WIDTH = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_start,
    input  logic [DATA_WIDTH-1:0] i_data_A,
    input  logic [DATA_WIDTH-1:0] i_data_B,
    input  logic                  i_borrow_in,
`ifdef GB80_SUB_COMPARE_EN
    input  logic                  i_compare,
`endif
    output logic                  o_ready,
    output logic                  o_valid,
    output logic [DATA_WIDTH-1:0] o_diff,
    output logic                  o_borrow_out,
    output logic                  o_half_borrow,
    output logic                  o_zero
);

    localparam int N       = DATA_WIDTH / SLICE_WIDTH;
    localparam int CW      = count_width(N);
    // This is the index of the slice whose MSB is bit 3. SLICE_WIDTH is
    // always 1, 2 or 4, so it divides 4 evenly.
    localparam int H_SLICE = 4 / SLICE_WIDTH - 1;

    localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);
    localparam logic [CW-1:0] CNT_H    = CW'(H_SLICE);

    alu_state_e state_reg, state_next;

    logic [CW-1:0]         cnt_reg;
    logic [DATA_WIDTH-1:0] a_reg;
    logic [DATA_WIDTH-1:0] b_reg;
    logic                  borrow_reg;
    logic [DATA_WIDTH-1:0] diff_reg;
    logic                  c_reg;
    logic                  h_reg;
    logic                  z_reg;
    logic                  valid_reg;
`ifdef GB80_SUB_COMPARE_EN
    logic                  compare_reg;
`endif

    // Split the captured operands into slices so the single slice
    // subtractor can be fed by a plain array index.
    logic [SLICE_WIDTH-1:0] a_slices [N];
    logic [SLICE_WIDTH-1:0] b_slices [N];

    for (genvar gi = 0; gi < N; gi++) begin : g_slice
        assign a_slices[gi] = a_reg[gi*SLICE_WIDTH +: SLICE_WIDTH];
        assign b_slices[gi] = b_reg[gi*SLICE_WIDTH +: SLICE_WIDTH];
    end

    logic [SLICE_WIDTH-1:0] slice_diff;
    logic                   slice_borrow;

    slice_subtractor #(
        .SLICE_WIDTH(SLICE_WIDTH)
    ) u_slice (
        .a         (a_slices[cnt_reg]),
        .b         (b_slices[cnt_reg]),
        .borrow_in (borrow_reg),
        .diff      (slice_diff),
        .borrow_out(slice_borrow)
    );

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            ST_IDLE: if (i_start)              state_next = ST_RUN;
            ST_RUN:  if (cnt_reg == CNT_LAST)  state_next = ST_DONE;
            ST_DONE:                           state_next = ST_IDLE;
            default:                           state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Datapath and flags
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt_reg     <= '0;
            a_reg       <= '0;
            b_reg       <= '0;
            borrow_reg  <= 1'b0;
            diff_reg    <= '0;
            c_reg       <= 1'b0;
            h_reg       <= 1'b0;
            z_reg       <= 1'b0;
            valid_reg   <= 1'b0;
`ifdef GB80_SUB_COMPARE_EN
            compare_reg <= 1'b0;
`endif
        end else begin
            valid_reg <= 1'b0;
            unique case (state_reg)
                ST_IDLE: begin
                    if (i_start) begin
                        a_reg       <= i_data_A;
                        b_reg       <= i_data_B;
                        borrow_reg  <= i_borrow_in;
                        diff_reg    <= '0;
                        cnt_reg     <= '0;
`ifdef GB80_SUB_COMPARE_EN
                        compare_reg <= i_compare;
`endif
                    end
                end
                ST_RUN: begin
                    diff_reg[cnt_reg*SLICE_WIDTH +: SLICE_WIDTH] <= slice_diff;
                    borrow_reg <= slice_borrow;
                    if (cnt_reg == CNT_H) begin
                        h_reg <= slice_borrow;
                    end
                    cnt_reg <= cnt_reg + 1'b1;
                end
                ST_DONE: begin
                    c_reg     <= borrow_reg;
                    // Z is taken from the true difference before any
                    // compare-mode reload of the result register.
                    z_reg     <= (diff_reg == '0);
                    valid_reg <= 1'b1;
`ifdef GB80_SUB_COMPARE_EN
                    if (compare_reg) begin
                        diff_reg <= a_reg;
                    end
`endif
                end
                default: ;
            endcase
        end
    end

    assign o_ready       = (state_reg == ST_IDLE);
    assign o_valid       = valid_reg;
    assign o_diff        = diff_reg;
    assign o_borrow_out  = c_reg;
    assign o_half_borrow = h_reg;
    assign o_zero        = z_reg;

endmodule

// File: tb/tb_bit_subtractor_seq.sv
// ----------------------------------------------------------------------------
// tb_bit_subtractor_seq
// This is a self-checking bench for the default 8-bit / 4-bit-slice configuration.
// The expected values come from plain integer arithmetic on the operands.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_bit_subtractor_seq;

    localparam int DW  = 8;
    localparam int LAT = 3;   // edges from accept to o_valid (N+1)

    logic          i_clk = 1'b0;
    logic          i_rst_n;
    logic          i_start;
    logic [DW-1:0] i_data_A;
    logic [DW-1:0] i_data_B;
    logic          i_borrow_in;
`ifdef GB80_SUB_COMPARE_EN
    logic          i_compare;
`endif
    logic          o_ready;
    logic          o_valid;
    logic [DW-1:0] o_diff;
    logic          o_borrow_out;
    logic          o_half_borrow;
    logic          o_zero;

    int checks   = 0;
    int failures = 0;

    always #5 i_clk = ~i_clk;

    bit_subtractor_seq #(.DATA_WIDTH(DW), .SLICE_WIDTH(4)) dut (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_start      (i_start),
        .i_data_A     (i_data_A),
        .i_data_B     (i_data_B),
        .i_borrow_in  (i_borrow_in),
`ifdef GB80_SUB_COMPARE_EN
        .i_compare    (i_compare),
`endif
        .o_ready      (o_ready),
        .o_valid      (o_valid),
        .o_diff       (o_diff),
        .o_borrow_out (o_borrow_out),
        .o_half_borrow(o_half_borrow),
        .o_zero       (o_zero)
    );

    typedef struct {
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        logic          bin;
        logic [DW-1:0] diff;
        logic          c;
        logic          h;
        logic          z;
    } vec_t;

    vec_t vecs [4];

    // Values captured from the most recent operation
    logic [DW-1:0] got_diff;
    logic          got_c, got_h, got_z;
    int            got_lat;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", name, got, exp);
        end
    endtask

    // This is the reference model. It works on whole unsigned integers and does not use slices.
    task automatic model(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic bin,
                         output logic [DW-1:0] d, output logic c, output logic h, output logic z);
        int ia, ib, ibin;
        ia   = int'(a);
        ib   = int'(b);
        ibin = int'(bin);
        d = DW'(ia - ib - ibin);
        c = (ia < ib + ibin);
        h = ((ia % 16) < (ib % 16) + ibin);
        z = (d == '0);
    endtask

    // Run one operation. The task checks ready handshaking, latency and
    // pulse width, then leaves the result in the got_* variables.
    task automatic run_op(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic bin);
        @(negedge i_clk);
        check("ready_before_accept", 32'(o_ready), 32'd1);
        i_start     = 1'b1;
        i_data_A    = a;
        i_data_B    = b;
        i_borrow_in = bin;
        @(posedge i_clk);
        #1;
        i_start     = 1'b0;
        // Operands may change once they have been accepted.
        i_data_A    = DW'($urandom);
        i_data_B    = DW'($urandom);
        i_borrow_in = 1'($urandom);
        check("ready_low_after_accept", 32'(o_ready), 32'd0);
        got_lat = 0;
        while (got_lat < 12) begin
            @(posedge i_clk);
            #1;
            got_lat++;
            if (o_valid) break;
        end
        check("valid_latency", 32'(got_lat), 32'(LAT));
        got_diff = o_diff;
        got_c    = o_borrow_out;
        got_h    = o_half_borrow;
        got_z    = o_zero;
        @(posedge i_clk);
        #1;
        check("valid_one_cycle", 32'(o_valid), 32'd0);
        $display("op A=%02h B=%02h bin=%0d -> diff=%02h C=%0d H=%0d Z=%0d lat=%0d",
                 a, b, bin, got_diff, got_c, got_h, got_z, got_lat);
    endtask

    task automatic check_result(input string tag, input logic [DW-1:0] d, input logic c,
                                input logic h, input logic z);
        check({tag, "_diff"}, 32'(got_diff), 32'(d));
        check({tag, "_C"},    32'(got_c),    32'(c));
        check({tag, "_H"},    32'(got_h),    32'(h));
        check({tag, "_Z"},    32'(got_z),    32'(z));
    endtask

    initial begin
        logic [DW-1:0] ra, rb, ed;
        logic          rbin, ec, eh, ez;
        int            vcount;

        vecs[0] = '{a: 8'h3E, b: 8'h0F, bin: 1'b0, diff: 8'h2F, c: 1'b0, h: 1'b1, z: 1'b0};
        vecs[1] = '{a: 8'h10, b: 8'h20, bin: 1'b0, diff: 8'hF0, c: 1'b1, h: 1'b0, z: 1'b0};
        vecs[2] = '{a: 8'h01, b: 8'h00, bin: 1'b1, diff: 8'h00, c: 1'b0, h: 1'b0, z: 1'b1};
        vecs[3] = '{a: 8'h00, b: 8'hFF, bin: 1'b1, diff: 8'h00, c: 1'b1, h: 1'b1, z: 1'b1};

        i_rst_n     = 1'b0;
        i_start     = 1'b0;
        i_data_A    = '0;
        i_data_B    = '0;
        i_borrow_in = 1'b0;
`ifdef GB80_SUB_COMPARE_EN
        i_compare   = 1'b0;
`endif
        repeat (2) @(posedge i_clk);
        #1;
        check("rst_ready", 32'(o_ready),       32'd1);
        check("rst_valid", 32'(o_valid),       32'd0);
        check("rst_diff",  32'(o_diff),        32'd0);
        check("rst_C",     32'(o_borrow_out),  32'd0);
        check("rst_H",     32'(o_half_borrow), 32'd0);
        check("rst_Z",     32'(o_zero),        32'd0);
        @(negedge i_clk);
        i_rst_n = 1'b1;

        // Table-driven directed vectors
        for (int i = 0; i < 4; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].bin);
            check_result($sformatf("vec%0d", i), vecs[i].diff, vecs[i].c, vecs[i].h, vecs[i].z);
        end

        // The result must be held through several IDLE cycles.
        repeat (4) @(posedge i_clk);
        #1;
        check("hold_idle_diff", 32'(o_diff), 32'(vecs[3].diff));
        check("hold_idle_C",    32'(o_borrow_out), 32'(vecs[3].c));

        // Randomised operations checked against the model
        for (int i = 0; i < 24; i++) begin
            ra   = DW'($urandom);
            rb   = DW'($urandom);
            rbin = 1'($urandom);
            if (i == 0) begin ra = 8'h00; rb = 8'h00; rbin = 1'b0; end
            if (i == 1) begin ra = 8'hFF; rb = 8'hFF; rbin = 1'b1; end
            model(ra, rb, rbin, ed, ec, eh, ez);
            run_op(ra, rb, rbin);
            check_result($sformatf("rand%0d", i), ed, ec, eh, ez);
        end

        // i_start pulsed while RUN must not start a second operation.
        @(negedge i_clk);
        i_start = 1'b1; i_data_A = 8'h3E; i_data_B = 8'h0F; i_borrow_in = 1'b0;
        @(posedge i_clk);
        #1;
        i_data_A = 8'h99; i_data_B = 8'h11; i_borrow_in = 1'b1;   // start stays high for RUN
        @(posedge i_clk);
        #1;
        i_start = 1'b0;
        vcount = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge i_clk);
            #1;
            if (o_valid) vcount++;
        end
        check("busy_start_ignored_pulses", 32'(vcount), 32'd1);
        check("busy_start_ignored_diff",   32'(o_diff), 32'h2F);
        $display("op busy-start A=3E B=0F -> valid_pulses=%0d diff=%02h", vcount, o_diff);

        // Reset mid-RUN aborts the operation.
        @(negedge i_clk);
        i_start = 1'b1; i_data_A = 8'h10; i_data_B = 8'h20; i_borrow_in = 1'b0;
        @(posedge i_clk);
        #1;
        i_start = 1'b0;
        @(posedge i_clk);
        #1;
        i_rst_n = 1'b0;
        #2;
        check("abort_ready", 32'(o_ready),       32'd1);
        check("abort_valid", 32'(o_valid),       32'd0);
        check("abort_diff",  32'(o_diff),        32'd0);
        check("abort_C",     32'(o_borrow_out),  32'd0);
        check("abort_H",     32'(o_half_borrow), 32'd0);
        check("abort_Z",     32'(o_zero),        32'd0);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        vcount = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge i_clk);
            #1;
            if (o_valid) vcount++;
        end
        check("abort_no_valid", 32'(vcount), 32'd0);
        $display("op abort A=10 B=20 -> valid_pulses=%0d diff=%02h", vcount, o_diff);

        // The unit must still work after the abort.
        run_op(8'h10, 8'h20, 1'b0);
        check_result("post_abort", 8'hF0, 1'b1, 1'b0, 1'b0);

`ifdef GB80_SUB_COMPARE_EN
        i_compare = 1'b1;
        run_op(8'h42, 8'h42, 1'b0);
        check_result("compare_eq", 8'h42, 1'b0, 1'b0, 1'b1);
        run_op(8'h10, 8'h20, 1'b0);
        check_result("compare_lt", 8'h10, 1'b1, 1'b0, 1'b0);
        i_compare = 1'b0;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
